// File: rtl/bcd_sub_serial_if.sv
// Operation bus of the digit-serial BCD subtractor: start/operands in, done/result out.
// The requester owns start/a/b; the subtractor owns busy/done/diff/borrow/err.
interface bcd_sub_serial_if #(
    parameter int DIGITS = 4
);
    // Handshake: start is sampled only while busy=0. An accepted start raises busy
    // on the next cycle. done pulses for one cycle with diff/borrow/err valid.
    // The result holds until the next done. A start seen while busy is dropped.
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   diff;
    logic                  borrow;
    logic                  err;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, err
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, err
    );
endinterface

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor A-B, least-significant digit first, one digit per clock.
// Optional macro BCD_SUB_SIGN_MAG_EN adds a negate pass so diff is |A-B| with borrow as sign.
module bcd_sub_serial #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_sub_serial_if.slave    sub_if,
    output logic [1:0]         state_o
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_NEG  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q;
    logic            last_digit;
    logic [W-1:0]    a_q, b_q, r_q;
    logic            br_q;
    logic [W-1:0]    diff_q;
    logic            borrow_q, err_q;
    logic            in_bad;
    logic [3:0]      op_x, op_y, digit_r;
    logic [4:0]      t;
    logic            br_n;
    logic [W+3:0]    r_cat;
    logic [W-1:0]    r_shift;
`ifdef BCD_SUB_SIGN_MAG_EN
    logic            sign_q;
`endif

    function automatic logic any_bad(input logic [W-1:0] v);
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) any_bad = 1'b1;
        end
    endfunction

    assign in_bad     = any_bad(sub_if.a) | any_bad(sub_if.b);
    assign last_digit = (idx_q == CW'(DIGITS - 1));

    // One shared digit subtractor; the negate pass feeds 0 - r_i through it.
    always_comb begin
        op_x = a_q[3:0];
        op_y = b_q[3:0];
`ifdef BCD_SUB_SIGN_MAG_EN
        if (state_q == S_NEG) begin
            op_x = 4'd0;
            op_y = r_q[3:0];
        end
`endif
        t       = {1'b0, op_x} - {1'b0, op_y} - {4'd0, br_q};
        br_n    = t[4];
        digit_r = t[4] ? 4'(t + 5'd10) : t[3:0];
        r_cat   = {digit_r, r_q};
        r_shift = r_cat[W+3:4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (sub_if.start) state_d = in_bad ? S_DONE : S_SUB;
            S_SUB: begin
                if (last_digit) begin
`ifdef BCD_SUB_SIGN_MAG_EN
                    state_d = br_n ? S_NEG : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef BCD_SUB_SIGN_MAG_EN
            S_NEG:  if (last_digit) state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sub_if.busy   = (state_q != S_IDLE);
        sub_if.done   = (state_q == S_DONE);
        sub_if.diff   = diff_q;
        sub_if.borrow = borrow_q;
        sub_if.err    = err_q;
        state_o       = state_q;
    end

    // Operands shift right one digit per cycle; results shift in from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            br_q     <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sub_if.start) begin
                        a_q   <= sub_if.a;
                        b_q   <= sub_if.b;
                        r_q   <= '0;
                        br_q  <= 1'b0;
                        idx_q <= '0;
                    end
                end
                S_SUB: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    r_q   <= r_shift;
                    idx_q <= last_digit ? '0 : idx_q + 1'b1;
                    br_q  <= last_digit ? 1'b0 : br_n;
`ifdef BCD_SUB_SIGN_MAG_EN
                    if (last_digit) sign_q <= br_n;
`endif
                end
`ifdef BCD_SUB_SIGN_MAG_EN
                S_NEG: begin
                    r_q   <= r_shift;
                    br_q  <= br_n;
                    idx_q <= idx_q + 1'b1;
                end
`endif
                default: ;
            endcase

            // Result registers change only on entry to DONE.
            if (state_d == S_DONE && state_q != S_DONE) begin
                if (state_q == S_IDLE) begin
                    diff_q   <= '0;
                    borrow_q <= 1'b0;
                    err_q    <= 1'b1;
                end else begin
                    diff_q   <= r_shift;
                    err_q    <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
                    borrow_q <= (state_q == S_SUB) ? br_n : sign_q;
`else
                    borrow_q <= br_n;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_sub_serial.sv
// Randomized and directed bench for bcd_sub_serial against an integer-arithmetic model.
module tb_bcd_sub_serial;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W+1:0] exp_q[$];
    int           lat_q[$];
    logic [W+1:0] prev_res = '0;

    bcd_sub_serial_if #(.DIGITS(DIGITS)) sub_if ();

    bcd_sub_serial #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sub_if  (sub_if),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint x);
        logic [W-1:0] v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Packed {err, borrow, diff}.
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        longint ai, bi;
        if (is_bad(av) || is_bad(bv)) return {2'b10, {W{1'b0}}};
        ai = bcd2int(av);
        bi = bcd2int(bv);
        if (ai >= bi) return {2'b00, int2bcd(ai - bi)};
`ifdef BCD_SUB_SIGN_MAG_EN
        return {2'b01, int2bcd(bi - ai)};
`else
        return {2'b01, int2bcd(ai - bi + pow10(DIGITS))};
`endif
    endfunction

    function automatic int model_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
        if (is_bad(av) || is_bad(bv)) return 1;
`ifdef BCD_SUB_SIGN_MAG_EN
        if (bcd2int(av) < bcd2int(bv)) return 2 * DIGITS + 1;
`endif
        return DIGITS + 1;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit inject);
        int           cyc = 0;
        bit           got_done = 1'b0;
        logic [W+1:0] exp_r;
        int           exp_l;
        @(negedge clk);
        sub_if.a = av;
        sub_if.b = bv;
        sub_if.start = 1'b1;
        exp_q.push_back(model(av, bv));
        lat_q.push_back(model_lat(av, bv));
        while (!got_done && cyc < 4 * DIGITS + 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                sub_if.start = 1'b0;
                sub_if.a = W'($urandom);
                sub_if.b = W'($urandom);
                check("busy_c1", sub_if.busy, 1);
                if (!sub_if.done)
                    check("hold_c1", {sub_if.err, sub_if.borrow, sub_if.diff}, prev_res);
            end
            if (inject && cyc == 2) begin
                sub_if.a = 16'h1111;
                sub_if.b = 16'h0001;
                sub_if.start = 1'b1;
            end
            if (inject && cyc == 3) sub_if.start = 1'b0;
            if (sub_if.done) got_done = 1'b1;
        end
        exp_r = exp_q.pop_front();
        exp_l = lat_q.pop_front();
        check("done_seen", got_done, 1);
        check("latency", cyc, exp_l);
        check("result", {sub_if.err, sub_if.borrow, sub_if.diff}, exp_r);
        check("busy_at_done", sub_if.busy, 1);
        prev_res = exp_r;
        @(negedge clk);
        check("done_pulse", sub_if.done, 0);
        check("busy_fall", sub_if.busy, 0);
    endtask

    task automatic rand_operand(output logic [W-1:0] v);
        v = '0;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W+1:0] r2;
        int cyc, d1, d2, n_done;

        sub_if.start = 1'b0;
        sub_if.a = '0;
        sub_if.b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   sub_if.busy, 0);
        check("rst_done",   sub_if.done, 0);
        check("rst_diff",   sub_if.diff, 0);
        check("rst_borrow", sub_if.borrow, 0);
        check("rst_err",    sub_if.err, 0);
        rst_n = 1'b1;

        // Directed cases
        run_op(16'h0042, 16'h0017, 1'b0);
        run_op(16'h0100, 16'h0001, 1'b0);
        run_op(16'h0003, 16'h0005, 1'b0);
        run_op(16'h00A0, 16'h0001, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b0);
        run_op(16'h0000, 16'h9999, 1'b0);
        run_op(16'h9999, 16'h0000, 1'b0);
        run_op(16'h0042, 16'h0017, 1'b1);

        // start held high: second op begins on the first IDLE cycle after DONE
        @(negedge clk);
        sub_if.a = 16'h0042;
        sub_if.b = 16'h0017;
        sub_if.start = 1'b1;
        cyc = 0; d1 = 0; d2 = 0;
        r2 = '0;
        while (d2 == 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (sub_if.done) begin
                if (d1 == 0) begin
                    d1 = cyc;
                    sub_if.a = 16'h0100;
                    sub_if.b = 16'h0001;
                end else begin
                    d2 = cyc;
                    r2 = {sub_if.err, sub_if.borrow, sub_if.diff};
                    sub_if.start = 1'b0;
                end
            end
        end
        check("hold_done1", d1, model_lat(16'h0042, 16'h0017));
        check("hold_done2", d2, model_lat(16'h0042, 16'h0017) + 1 + model_lat(16'h0100, 16'h0001));
        check("hold_result2", r2, model(16'h0100, 16'h0001));
        prev_res = model(16'h0100, 16'h0001);
        @(negedge clk);

        // Reset in cycle 3 aborts the operation
        @(negedge clk);
        sub_if.a = 16'h0042;
        sub_if.b = 16'h0017;
        sub_if.start = 1'b1;
        @(negedge clk);
        sub_if.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   sub_if.busy, 0);
        check("abort_done",   sub_if.done, 0);
        check("abort_diff",   sub_if.diff, 0);
        check("abort_borrow", sub_if.borrow, 0);
        check("abort_err",    sub_if.err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (sub_if.done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        prev_res = '0;
        run_op(16'h0042, 16'h0017, 1'b0);

        // Randomized operations, with some equal/zero boundary operands
        for (int k = 0; k < 40; k++) begin
            rand_operand(ra);
            rand_operand(rb);
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: rb = '0;
                2: ra = '0;
                default: ;
            endcase
            run_op(ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
